// File: rtl/vector_alu_result_stage_pkg.sv
// Shared vector definitions for the ALU result stage: default geometry, lane vector type, saturation constants.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package vector_alu_result_stage_pkg;

    localparam int DEF_DATA_WIDTH = 19;
    localparam int DEF_LANES      = 6;
    localparam int RD_W           = 5;
    localparam int CNT_W          = 16;

    // Lane vector at the default geometry; lane i occupies element [i].
    typedef logic [DEF_LANES-1:0][DEF_DATA_WIDTH-1:0] lane_vec_t;

    // Two's-complement extremes of a w-bit lane, returned zero-extended to 64 bits.
    function automatic logic [63:0] sat_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/vector_alu_result_stage_if.sv
// Upstream/downstream bus of the ALU result stage: valid/ready handshakes plus per-lane data and flags.
// Latency: n/a (wires only).
// Backpressure: in_ready from the stage, out_ready from the consumer.
// Modports: slave = the stage (consumes in_*, produces out_*); master = the environment around it.
interface vector_alu_result_stage_if
    import vector_alu_result_stage_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LANES      = DEF_LANES
);
    logic                              in_valid;
    logic                              in_ready;
    logic [LANES-1:0][DATA_WIDTH-1:0]  in_result;
    logic [LANES-1:0]                  in_c;
    logic [LANES-1:0]                  in_v;
    logic [LANES-1:0]                  in_n;
    logic                              in_sat;
    logic [RD_W-1:0]                   in_rd;
    logic                              in_we;

    logic                              out_valid;
    logic                              out_ready;
    logic [LANES-1:0][DATA_WIDTH-1:0]  out_result;
    logic [LANES-1:0]                  out_c;
    logic [LANES-1:0]                  out_v;
    logic [LANES-1:0]                  out_n;
    logic [LANES-1:0]                  out_z;
    logic [RD_W-1:0]                   out_rd;
    logic                              out_we;

    modport slave (
        input  in_valid, in_result, in_c, in_v, in_n, in_sat, in_rd, in_we, out_ready,
        output in_ready, out_valid, out_result, out_c, out_v, out_n, out_z, out_rd, out_we
    );

    modport master (
        output in_valid, in_result, in_c, in_v, in_n, in_sat, in_rd, in_we, out_ready,
        input  in_ready, out_valid, out_result, out_c, out_v, out_n, out_z, out_rd, out_we
    );

endinterface

// File: rtl/vector_alu_result_stage_lane_saturate.sv
// Single-lane saturation: clamps an overflowed lane to the signed extreme implied by its sign flag.
// Latency: combinational.
// Backpressure: none.
// Ports: i_result/i_v/i_n/i_sat in; o_result (clamped or passed through), o_saturated out.
module lane_saturate
    import vector_alu_result_stage_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] i_result,
    input  logic                  i_v,
    input  logic                  i_n,
    input  logic                  i_sat,
    output logic [DATA_WIDTH-1:0] o_result,
    output logic                  o_saturated
);

    localparam logic [DATA_WIDTH-1:0] SAT_MAX = DATA_WIDTH'(sat_max(DATA_WIDTH));
    localparam logic [DATA_WIDTH-1:0] SAT_MIN = DATA_WIDTH'(sat_min(DATA_WIDTH));

    assign o_saturated = i_sat & i_v;

    // On overflow the wrapped sign is the opposite of the true one: a negative-looking
    // overflowed result really overflowed upward, so it clamps to the maximum.
    always_comb begin
        o_result = i_result;
        if (o_saturated) begin
            o_result = i_n ? SAT_MAX : SAT_MIN;
        end
    end

endmodule

// File: rtl/vector_alu_result_stage.sv
// ALU result stage: per-lane saturation, zero flags, 2-entry skid buffer, saturated-lane counter.
// Latency: 1 cycle from accept to out_valid when the output register is empty or draining.
// Backpressure: in_ready is registered and drops only once the skid entry is occupied.
// Ports: clk, rst (async, active-high), flush (sync), stage_bus (slave modport), sat_count (sticky at 0xFFFF).
module vector_alu_result_stage
    import vector_alu_result_stage_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LANES      = DEF_LANES
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    vector_alu_result_stage_if.slave      stage_bus,
    output logic [CNT_W-1:0]              sat_count
);

    typedef struct packed {
        logic [LANES-1:0][DATA_WIDTH-1:0] result;
        logic [LANES-1:0]                 c;
        logic [LANES-1:0]                 v;
        logic [LANES-1:0]                 n;
        logic [LANES-1:0]                 z;
        logic [RD_W-1:0]                  rd;
        logic                             we;
    } beat_t;

    logic [LANES-1:0][DATA_WIDTH-1:0] w_sat_result;
    logic [LANES-1:0]                 w_sat_lane;
    logic [LANES-1:0]                 w_zero;
    beat_t                            w_in_beat;
    logic [CNT_W-1:0]                 w_sat_num;
    logic [CNT_W:0]                   w_cnt_sum;
    logic [CNT_W-1:0]                 w_cnt_next;
    logic                             w_in_fire;
    logic                             w_main_free;

    beat_t            r_main;
    beat_t            r_skid;
    logic             r_main_vld;
    logic             r_skid_vld;
    logic             r_in_ready;
    logic [CNT_W-1:0] r_sat_count;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        lane_saturate #(.DATA_WIDTH(DATA_WIDTH)) u_lane_saturate (
            .i_result    (stage_bus.in_result[g]),
            .i_v         (stage_bus.in_v[g]),
            .i_n         (stage_bus.in_n[g]),
            .i_sat       (stage_bus.in_sat),
            .o_result    (w_sat_result[g]),
            .o_saturated (w_sat_lane[g])
        );
        assign w_zero[g] = (w_sat_result[g] == '0);
    end

    always_comb begin
        w_in_beat        = '0;
        w_in_beat.result = w_sat_result;
        w_in_beat.c      = stage_bus.in_c;
        w_in_beat.v      = stage_bus.in_v;
        w_in_beat.n      = stage_bus.in_n;
        w_in_beat.z      = w_zero;
        w_in_beat.rd     = stage_bus.in_rd;
        w_in_beat.we     = stage_bus.in_we;
    end

    always_comb begin
        w_sat_num = '0;
        for (int i = 0; i < LANES; i++) begin
            w_sat_num = w_sat_num + CNT_W'(w_sat_lane[i]);
        end
    end

    assign w_cnt_sum  = {1'b0, r_sat_count} + {1'b0, w_sat_num};
    assign w_cnt_next = w_cnt_sum[CNT_W] ? '1 : w_cnt_sum[CNT_W-1:0];

    // A beat offered during flush is dropped, so it never counts as accepted.
    assign w_in_fire   = stage_bus.in_valid & r_in_ready & ~flush;
    assign w_main_free = ~r_main_vld | stage_bus.out_ready;

    // r_in_ready always tracks ~r_skid_vld, so an accept never coincides with a full skid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main      <= '0;
            r_skid      <= '0;
            r_main_vld  <= 1'b0;
            r_skid_vld  <= 1'b0;
            r_in_ready  <= 1'b1;
            r_sat_count <= '0;
        end else if (flush) begin
            r_main_vld <= 1'b0;
            r_skid_vld <= 1'b0;
            r_in_ready <= 1'b1;
        end else begin
            if (w_in_fire) begin
                r_sat_count <= w_cnt_next;
            end
            if (w_main_free) begin
                if (r_skid_vld) begin
                    r_main     <= r_skid;
                    r_main_vld <= 1'b1;
                    r_skid_vld <= 1'b0;
                    r_in_ready <= 1'b1;
                end else if (w_in_fire) begin
                    r_main     <= w_in_beat;
                    r_main_vld <= 1'b1;
                end else begin
                    r_main_vld <= 1'b0;
                end
            end else if (w_in_fire) begin
                r_skid     <= w_in_beat;
                r_skid_vld <= 1'b1;
                r_in_ready <= 1'b0;
            end
        end
    end

    assign stage_bus.in_ready   = r_in_ready;
    assign stage_bus.out_valid  = r_main_vld;
    assign stage_bus.out_result = r_main.result;
    assign stage_bus.out_c      = r_main.c;
    assign stage_bus.out_v      = r_main.v;
    assign stage_bus.out_n      = r_main.n;
    assign stage_bus.out_z      = r_main.z;
    assign stage_bus.out_rd     = r_main.rd;
    assign stage_bus.out_we     = r_main.we & r_main_vld;
    assign sat_count            = r_sat_count;

endmodule

// File: tb/tb_vector_alu_result_stage.sv
// Directed bench for the ALU result stage: reset, single beat, saturation, zero flags,
// backpressure ordering, flush, mid-transfer reset and counter clamping.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
module tb_vector_alu_result_stage;
    import vector_alu_result_stage_pkg::*;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [15:0] sat_count;

    int checks;
    int errors;

    vector_alu_result_stage_if #(.DATA_WIDTH(19), .LANES(6)) bus_if ();

    vector_alu_result_stage #(.DATA_WIDTH(19), .LANES(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .stage_bus (bus_if),
        .sat_count (sat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input lane_vec_t res, input logic [5:0] c, input logic [5:0] v,
                         input logic [5:0] n, input logic sat, input logic [4:0] rd, input logic we);
        bus_if.in_valid  = 1'b1;
        bus_if.in_result = res;
        bus_if.in_c      = c;
        bus_if.in_v      = v;
        bus_if.in_n      = n;
        bus_if.in_sat    = sat;
        bus_if.in_rd     = rd;
        bus_if.in_we     = we;
    endtask

    task automatic idle();
        bus_if.in_valid = 1'b0;
    endtask

    function automatic lane_vec_t fill(input logic [18:0] x);
        lane_vec_t r;
        for (int i = 0; i < 6; i++) r[i] = x;
        return r;
    endfunction

    lane_vec_t va, vb, vc, vexp, beat_a, beat_b, beat_c;

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        flush  = 1'b0;
        bus_if.in_valid  = 1'b0;
        bus_if.in_result = '0;
        bus_if.in_c      = '0;
        bus_if.in_v      = '0;
        bus_if.in_n      = '0;
        bus_if.in_sat    = 1'b0;
        bus_if.in_rd     = '0;
        bus_if.in_we     = 1'b0;
        bus_if.out_ready = 1'b0;
        beat_a = fill(19'h00011);
        beat_b = fill(19'h00022);
        beat_c = fill(19'h00033);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", bus_if.out_valid, 1'b0);
        chk("rst_in_ready", bus_if.in_ready, 1'b1);
        chk("rst_sat_count", sat_count, 16'h0000);
        chk("rst_out_we", bus_if.out_we, 1'b0);
        chk("rst_out_result", bus_if.out_result, '0);
        chk("rst_flags", {bus_if.out_c, bus_if.out_v, bus_if.out_n, bus_if.out_z}, 24'h0);
        chk("rst_out_rd", bus_if.out_rd, 5'd0);
        rst = 1'b0;

        // Single beat, lanes 1..6, one cycle latency
        for (int i = 0; i < 6; i++) va[i] = 19'(i + 1);
        bus_if.out_ready = 1'b1;
        drive(va, 6'b0, 6'b0, 6'b0, 1'b0, 5'd7, 1'b1);
        #2;
        chk("single_pre_edge_valid", bus_if.out_valid, 1'b0);
        tick();
        idle();
        chk("single_valid", bus_if.out_valid, 1'b1);
        chk("single_result", bus_if.out_result, va);
        chk("single_z", bus_if.out_z, 6'b000000);
        chk("single_rd", bus_if.out_rd, 5'd7);
        chk("single_we", bus_if.out_we, 1'b1);
        tick();
        chk("single_drained_valid", bus_if.out_valid, 1'b0);
        chk("single_drained_we", bus_if.out_we, 1'b0);

        // Saturation: lane0 overflow with n=0 -> min, lane1 overflow with n=1 -> max
        vb = va;
        vb[0] = 19'h40001;
        vb[1] = 19'h12345;
        drive(vb, 6'b100001, 6'b000011, 6'b000010, 1'b1, 5'd3, 1'b1);
        tick();
        vexp = vb;
        vexp[0] = 19'h40000;
        vexp[1] = 19'h3FFFF;
        chk("sat_result", bus_if.out_result, vexp);
        chk("sat_count_plus2", sat_count, 16'd2);
        chk("sat_flags_cvn", {bus_if.out_c, bus_if.out_v, bus_if.out_n}, {6'b100001, 6'b000011, 6'b000010});
        drive(vb, 6'b100001, 6'b000011, 6'b000010, 1'b0, 5'd3, 1'b1);
        tick();
        idle();
        chk("nosat_passthrough", bus_if.out_result, vb);
        chk("nosat_count_held", sat_count, 16'd2);

        // Zero flags
        drive(fill(19'h0), 6'b0, 6'b0, 6'b0, 1'b0, 5'd1, 1'b0);
        tick();
        chk("zero_all", bus_if.out_z, 6'b111111);
        chk("zero_we_low", bus_if.out_we, 1'b0);
        vc = fill(19'h0);
        vc[3] = 19'h40000;
        drive(vc, 6'b0, 6'b0, 6'b001000, 1'b0, 5'd1, 1'b0);
        tick();
        idle();
        chk("zero_lane3_n", bus_if.out_n, 6'b001000);
        chk("zero_lane3_z", bus_if.out_z, 6'b110111);
        chk("zero_lane3_result", bus_if.out_result, vc);
        tick();

        // Backpressure: A to main, B to skid, C refused until release
        bus_if.out_ready = 1'b0;
        drive(beat_a, 6'b0, 6'b0, 6'b0, 1'b0, 5'd1, 1'b1);
        tick();
        chk("bp_a_valid", bus_if.out_valid, 1'b1);
        chk("bp_a_in_ready", bus_if.in_ready, 1'b1);
        drive(beat_b, 6'b0, 6'b0, 6'b0, 1'b0, 5'd2, 1'b1);
        tick();
        chk("bp_hold_a", bus_if.out_result, beat_a);
        chk("bp_skid_full_in_ready", bus_if.in_ready, 1'b0);
        drive(beat_c, 6'b0, 6'b0, 6'b0, 1'b0, 5'd3, 1'b1);
        tick();
        chk("bp_c_refused_in_ready", bus_if.in_ready, 1'b0);
        chk("bp_still_a_rd", bus_if.out_rd, 5'd1);
        bus_if.out_ready = 1'b1;
        tick();
        chk("bp_b_rd", bus_if.out_rd, 5'd2);
        chk("bp_b_result", bus_if.out_result, beat_b);
        chk("bp_b_in_ready", bus_if.in_ready, 1'b1);
        tick();
        idle();
        chk("bp_c_rd", bus_if.out_rd, 5'd3);
        chk("bp_c_result", bus_if.out_result, beat_c);
        tick();
        chk("bp_empty", bus_if.out_valid, 1'b0);

        // Flush with main full and a saturating input accepted-eligible
        bus_if.out_ready = 1'b0;
        drive(beat_a, 6'b0, 6'b0, 6'b0, 1'b0, 5'd1, 1'b1);
        tick();
        drive(fill(19'h00005), 6'b0, 6'b111111, 6'b0, 1'b1, 5'd9, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle();
        chk("flush1_valid", bus_if.out_valid, 1'b0);
        chk("flush1_in_ready", bus_if.in_ready, 1'b1);
        chk("flush1_count", sat_count, 16'd2);

        // Flush with main and skid full plus a new input
        drive(beat_a, 6'b0, 6'b0, 6'b0, 1'b0, 5'd1, 1'b1);
        tick();
        drive(beat_b, 6'b0, 6'b0, 6'b0, 1'b0, 5'd2, 1'b1);
        tick();
        chk("flush2_full_in_ready", bus_if.in_ready, 1'b0);
        drive(fill(19'h00005), 6'b0, 6'b111111, 6'b0, 1'b1, 5'd9, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle();
        chk("flush2_valid", bus_if.out_valid, 1'b0);
        chk("flush2_in_ready", bus_if.in_ready, 1'b1);
        chk("flush2_count", sat_count, 16'd2);
        chk("flush2_we", bus_if.out_we, 1'b0);
        bus_if.out_ready = 1'b1;
        tick();
        chk("flush2_skid_gone", bus_if.out_valid, 1'b0);

        // Reset mid-transfer, then accept on the first edge after release
        bus_if.out_ready = 1'b0;
        drive(beat_a, 6'b0, 6'b0, 6'b0, 1'b0, 5'd1, 1'b1);
        tick();
        drive(beat_b, 6'b0, 6'b0, 6'b0, 1'b0, 5'd2, 1'b1);
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_valid", bus_if.out_valid, 1'b0);
        chk("midrst_in_ready", bus_if.in_ready, 1'b1);
        chk("midrst_count", sat_count, 16'd0);
        chk("midrst_we", bus_if.out_we, 1'b0);
        tick();
        rst = 1'b0;
        bus_if.out_ready = 1'b1;
        drive(beat_c, 6'b0, 6'b0, 6'b0, 1'b0, 5'd3, 1'b1);
        tick();
        idle();
        chk("postrst_valid", bus_if.out_valid, 1'b1);
        chk("postrst_rd", bus_if.out_rd, 5'd3);
        tick();

        // Counter clamp: 6 saturated lanes per beat
        drive(fill(19'h00001), 6'b0, 6'b111111, 6'b0, 1'b1, 5'd4, 1'b1);
        repeat (10922) @(posedge clk);
        #1;
        chk("cnt_before_clamp", sat_count, 16'hFFFC);
        chk("cnt_lane_min", bus_if.out_result, fill(19'h40000));
        tick();
        chk("cnt_clamped", sat_count, 16'hFFFF);
        repeat (3) @(posedge clk);
        #1;
        chk("cnt_held", sat_count, 16'hFFFF);
        idle();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vector_alu_result_stage.md
VECTOR_ALU_RESULT_STAGE -- requirements
Module: vector_alu_result_stage

Interface
REQ-001 Parameter DATA_WIDTH, default 19, lane width in bits.
REQ-002 Parameter LANES, default 6, number of vector lanes.
REQ-003 The block SHALL use one clock, clk, and an asynchronous, active-high reset, rst.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 flush  input  1  synchronous pipeline flush.
REQ-007 in_valid  input  1  upstream adder/subtractor result valid.
REQ-008 in_ready  output  1  stage can accept input.
REQ-009 in_result  input  LANES x DATA_WIDTH  per-lane sum/difference.
REQ-010 in_c, in_v, in_n  input  LANES each  per-lane carry, overflow, negative flags.
REQ-011 in_sat  input  1  saturate overflowed lanes.
REQ-012 in_rd  input  5  destination vector register; in_we  input  1  write enable.
REQ-013 out_valid  output  1; out_ready  input  1  downstream handshake.
REQ-014 out_result  output  LANES x DATA_WIDTH; out_c, out_v, out_n, out_z  output  LANES each.
REQ-015 out_rd  output  5; out_we  output  1.
REQ-016 sat_count  output  16  count of lanes saturated since reset.

Function
REQ-017 A transfer SHALL occur on a rising edge when valid and ready are both high on that side.
REQ-018 Latency SHALL be 1 cycle: data accepted at edge k appears on out_* after edge k when the output register is empty or draining.
REQ-019 The stage SHALL be a 2-entry skid buffer: main register drives outputs; skid register captures an accepted input when main is held (out_valid=1, out_ready=0).
REQ-020 in_ready SHALL be a registered signal, equal to NOT skid_valid.
REQ-021 When main drains and skid is full, skid SHALL move to main on the same edge.
REQ-022 Order SHALL be preserved; no beat dropped or duplicated except by flush.
REQ-023 Saturation: when in_sat=1 and in_v[i]=1, lane i SHALL become the signed maximum (0x3FFFF for width 19) if in_n[i]=1, otherwise the signed minimum (0x40000 for width 19).
REQ-024 Saturation SHALL be applied before registering; flags out_c, out_v, and out_n SHALL be passed through unmodified.
REQ-025 out_z[i] SHALL be 1 iff the registered lane i result, after saturation, is all zeros.
REQ-026 sat_count SHALL add the number of saturated lanes (0..LANES) per accepted beat and hold at 0xFFFF instead of wrapping.
REQ-027 flush=1 SHALL clear main and skid valid bits at the next edge, drop any input offered that cycle, and not update sat_count for it.
REQ-028 Flush and reset SHALL NOT clear sat_count except rst.
REQ-029 out_we SHALL be forced to 0 whenever out_valid=0.
REQ-030 Data registers SHALL load only on accepted transfers; they hold otherwise.

Reset
REQ-031 On rst: out_valid=0, skid_valid=0, in_ready=1, sat_count=0, out_we=0; out_result, flags, and out_rd SHALL be 0.
REQ-032 rst asserted mid-transfer SHALL discard all held beats immediately; the first accept SHALL be allowed on the first edge after deassertion.

Structure
REQ-033 DATA_WIDTH/LANES defaults, the lane vector typedef, and the SAT_MAX/SAT_MIN constant functions SHALL live in the shared vector package.
REQ-034 One sub-module, lane_saturate (single lane: result, v, n, sat -> result, saturated), SHALL be instantiated LANES times via generate.

Verification
REQ-035 Single beat: lanes 1,2,3,4,5,6 with out_ready=1 -> out_valid exactly one cycle later with identical data and out_z=0.
REQ-036 Saturation: lane0=0x40001, v=1, n=0, sat=1 -> 0x40000; lane1 v=1, n=1 -> 0x3FFFF; sat_count += 2; with sat=0 the lanes pass through unchanged.
REQ-037 Backpressure: hold out_ready=0 while streaming beats A, B, C -> A and B are accepted and in_ready falls; on release, A, B, C emerge in order with no loss.
REQ-038 Zero flags: all lanes 0 -> out_z=6'b111111; lane3=0x40000 -> out_n[3] is passed through and out_z[3]=0.
REQ-039 Flush with both entries full plus a new input -> out_valid=0 and in_ready=1 next cycle, and sat_count is unchanged.
REQ-040 Counter: 10923 beats with all 6 lanes saturating -> sat_count=0xFFFF and it stays there.
